cordic_sincos_collect: RTL and testbench
========================================

# cordic_sincos_collect

Output collector for the bit-serial CORDIC pipeline. It sits directly downstream of the final `cordic_element` stage and receives that stage's 2-bit X (cosine) and Y (sine) digit streams, LSB digit first. It reassembles each 12-bit word, applies the invert-sign flag for quadrant folding, and saturates. It then presents a parallel signed sine/cosine sample to the NCO output logic through a valid/ready handshake.

## Interface
Parameters:
- `W`, 12: reassembled word width; must equal 2 × `NDIG`.
- `NDIG`, 6: digits per word.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy_i`  in  1  one-cycle frame-start strobe; digits follow on the next `NDIG` cycles.
- `x_i`  in  2  cosine digit stream, LSB digit first.
- `y_i`  in  2  sine digit stream, LSB digit first.
- `is_i`  in  1  invert-sign flag for the frame; sampled in FINAL.
- `cos_o`  out  W  signed cosine result.
- `sin_o`  out  W  signed sine result.
- `sat_o`  out  1  the held sample was saturated.
- `out_vld_o`  out  1  held sample is valid.
- `out_rdy_i`  in  1  consumer accepts the sample.
- `ovf_o`  out  1  sticky: a completed frame was dropped.
- `err_o`  out  1  sticky: `rdy_i` was asserted while a frame was being collected.

## Operation
- FSM states:
  - IDLE: accepts `rdy_i`; on `rdy_i` goes to LOAD with digit counter = 0.
  - LOAD: captures `x_i`/`y_i` into digit slot `cnt` on every edge. After slot `NDIG-1` it goes to FINAL.
  - FINAL: one cycle. Samples `is_i`, runs the sign/saturate datapath and writes the output slot. Goes to LOAD if `rdy_i` is high in this cycle, otherwise to IDLE.
- `rdy_i` in LOAD is ignored: no restart, `err_o` is set, and the current frame completes unchanged.
- Word assembly: digit k goes to bits [2k+1:2k]. The word is interpreted as two's complement.
- Sign correction: when `is_i` = 1, each word is negated.
  - The negation of −2^(W−1) saturates to 2^(W−1)−1, and `sat_o` is set for that sample.
  - When `is_i` = 0 the word passes unchanged and `sat_o` = 0.
- Output slot (single entry):
  - FINAL writes the slot if it is empty, or if it is being drained in the same cycle (`out_vld_o` & `out_rdy_i`).
  - Otherwise the new frame is dropped, the old sample is kept, and `ovf_o` is set.
- Handshake: the sample transfers on an edge where `out_vld_o` & `out_rdy_i` are both high. `cos_o`, `sin_o` and `sat_o` stay stable while `out_vld_o` is high and the sample has not been accepted.
- `ovf_o` and `err_o` clear only on reset.

## Timing
- A `rdy_i` at cycle 0 has its digits sampled at the ends of cycles 1…6, enters FINAL in cycle 7, and gives `out_vld_o` high from cycle 8. Latency is 8 cycles.
- Minimum frame period is 7 cycles: `rdy_i` may be asserted in FINAL.
- Reset values:
  - FSM in IDLE, `cnt` = 0.
  - `cos_o` = 0, `sin_o` = 0, `sat_o` = 0.
  - `out_vld_o` = 0, `ovf_o` = 0, `err_o` = 0.
- Reset asserted mid-frame discards the partial word immediately. The frame is not resumed after release.
- Simultaneous drain and FINAL in the same cycle: the new sample replaces the old one, `out_vld_o` stays high, and there is no overflow.

## Structure
- Shared package `cordic_pkg`: `W`, `NDIG`, digit width = 2, the FSM state enum (IDLE, LOAD, FINAL), and a `sat_neg` function (negate with saturation), which `cordic_element` variants also reuse.
- One sub-module, `digit_deser`: a `NDIG`-slot shift-in register with a load-enable and slot index. It is instantiated twice, once for X and once for Y.

## Test plan
- `rdy_i` pulse, X digits 2,0,1,3,0,1 (0x4D2 = 1234), Y same, `is_i` = 0, `out_rdy_i` = 1 → cycle 8: `cos_o` = `sin_o` = 1234, `sat_o` = 0, `out_vld_o` one cycle.
- Same stream with `is_i` = 1 → `cos_o` = `sin_o` = −1234 (0xB2E), `sat_o` = 0.
- X digits 0,0,0,0,0,2 (0x800 = −2048), `is_i` = 1 → `cos_o` = 2047 (0x7FF), `sat_o` = 1.
- Two frames at 7-cycle period with `out_rdy_i` = 0 → first sample held, second dropped, `ovf_o` = 1. Raise `out_rdy_i` → first sample transfers, `ovf_o` stays 1.
- `rdy_i` re-pulsed at cycle 3 of a frame → `err_o` = 1, original frame result is correct at cycle 8, and no second sample appears.
- `rst` asserted at cycle 4 of a frame, then a clean frame → all outputs are 0 during reset, and only the clean frame produces `out_vld_o`, with correct values.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: word geometry, collector FSM states and saturating negate.
package cordic_pkg;

    localparam int W     = 12;
    localparam int NDIG  = 6;
    localparam int DIG_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FINAL
    } state_e;

    function automatic logic is_most_neg(input logic [W-1:0] a);
        return a == {1'b1, {(W-1){1'b0}}};
    endfunction

    // Two's complement negate; the most negative value clamps to the most positive.
    function automatic logic [W-1:0] sat_neg(input logic [W-1:0] a);
        if (is_most_neg(a)) begin
            return {1'b0, {(W-1){1'b1}}};
        end
        return (~a) + W'(1);
    endfunction

endpackage

// File: rtl/digit_deser.sv
// NDIG-slot digit capture register: writes dig_i into slot idx_i when ld_i is high.
// Latency 1 cycle per digit; no backpressure, the caller sequences the slot index.
module digit_deser #(
    parameter int NDIG = 6,
    parameter int DW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ld_i,
    input  logic [$clog2(NDIG)-1:0] idx_i,
    input  logic [DW-1:0]           dig_i,
    output logic [NDIG*DW-1:0]      word_o
);

    logic [NDIG-1:0][DW-1:0] slot_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
        end else if (ld_i) begin
            slot_q[idx_i] <= dig_i;
        end
    end

    assign word_o = slot_q;

endmodule

// File: rtl/cordic_sincos_collect.sv
// Reassembles LSB-first X/Y digit streams, applies sign inversion with saturation, holds one sample.
// Latency 8 cycles rdy_i -> out_vld_o; a frame finishing while the slot is held and not draining is dropped (ovf_o).
module cordic_sincos_collect #(
    parameter int W    = cordic_pkg::W,
    parameter int NDIG = cordic_pkg::NDIG
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy_i,
    input  logic [1:0]   x_i,
    input  logic [1:0]   y_i,
    input  logic         is_i,
    output logic [W-1:0] cos_o,
    output logic [W-1:0] sin_o,
    output logic         sat_o,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic         ovf_o,
    output logic         err_o
);

    import cordic_pkg::*;

    localparam int CW = $clog2(NDIG);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  cos_q, sin_q;
    logic          sat_q, vld_q, ovf_q, err_q;

    logic [W-1:0]  x_word, y_word;
    logic [W-1:0]  cos_d, sin_d;
    logic          sat_d;
    logic          ld;
    logic          slot_free;

    assign ld = (state_q == ST_LOAD);

    digit_deser #(.NDIG(NDIG), .DW(DIG_W)) u_deser_x (
        .clk    (clk),
        .rst    (rst),
        .ld_i   (ld),
        .idx_i  (cnt_q),
        .dig_i  (x_i),
        .word_o (x_word)
    );

    digit_deser #(.NDIG(NDIG), .DW(DIG_W)) u_deser_y (
        .clk    (clk),
        .rst    (rst),
        .ld_i   (ld),
        .idx_i  (cnt_q),
        .dig_i  (y_i),
        .word_o (y_word)
    );

    always_comb begin
        cos_d = x_word;
        sin_d = y_word;
        sat_d = 1'b0;
        if (is_i) begin
            cos_d = sat_neg(x_word);
            sin_d = sat_neg(y_word);
            sat_d = is_most_neg(x_word) | is_most_neg(y_word);
        end
    end

    // A draining slot counts as free, so back-to-back samples never overflow.
    assign slot_free = !vld_q || out_rdy_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
            sat_q   <= 1'b0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (vld_q && out_rdy_i) begin
                vld_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (rdy_i) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
                    end
                end
                ST_LOAD: begin
                    if (rdy_i) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == CW'(NDIG-1)) begin
                        state_q <= ST_FINAL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ST_FINAL: begin
                    if (slot_free) begin
                        cos_q <= cos_d;
                        sin_q <= sin_d;
                        sat_q <= sat_d;
                        vld_q <= 1'b1;
                    end else begin
                        ovf_q <= 1'b1;
                    end
                    state_q <= rdy_i ? ST_LOAD : ST_IDLE;
                    cnt_q   <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign cos_o     = cos_q;
    assign sin_o     = sin_q;
    assign sat_o     = sat_q;
    assign out_vld_o = vld_q;
    assign ovf_o     = ovf_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_cordic_sincos_collect.sv
// Scoreboard bench: stimulus pushes model samples, a negedge monitor compares every valid output cycle.
module tb_cordic_sincos_collect;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_i;
    logic [1:0]  x_i, y_i;
    logic        is_i;
    logic [11:0] cos_o, sin_o;
    logic        sat_o, out_vld_o, out_rdy_i, ovf_o, err_o;

    cordic_sincos_collect #(.W(12), .NDIG(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy_i     (rdy_i),
        .x_i       (x_i),
        .y_i       (y_i),
        .is_i      (is_i),
        .cos_o     (cos_o),
        .sin_o     (sin_o),
        .sat_o     (sat_o),
        .out_vld_o (out_vld_o),
        .out_rdy_i (out_rdy_i),
        .ovf_o     (ovf_o),
        .err_o     (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] c;
        logic [11:0] s;
        logic        sat;
    } smp_t;

    smp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   rdy_mode   = 0;
    logic exp_ovf    = 1'b0;
    logic exp_err    = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Signed value, negated on request, clamped into the 12-bit signed range.
    function automatic logic [11:0] ref_word(input logic [11:0] w, input logic inv, output logic sat);
        int v;
        v   = $signed(w);
        sat = 1'b0;
        if (inv) v = -v;
        if (v > 2047) begin
            v   = 2047;
            sat = 1'b1;
        end
        return v[11:0];
    endfunction

    function automatic smp_t ref_model(input logic [11:0] x, input logic [11:0] y, input logic inv);
        smp_t r;
        logic sx, sy;
        r.c   = ref_word(x, inv, sx);
        r.s   = ref_word(y, inv, sy);
        r.sat = sx | sy;
        return r;
    endfunction

    task automatic set_ordy();
        case (rdy_mode)
            0:       out_rdy_i = 1'b1;
            1:       out_rdy_i = 1'($urandom_range(0, 1));
            default: out_rdy_i = 1'b0;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_ordy();
    endtask

    // Starts in the current cycle (cycle 0) and returns inside the FINAL cycle.
    task automatic frame(input logic [11:0] x, input logic [11:0] y, input logic inv, input int glitch);
        rdy_i = 1'b1;
        x_i   = 2'($urandom);
        y_i   = 2'($urandom);
        for (int k = 0; k < 6; k++) begin
            tick();
            rdy_i = (glitch == k + 1);
            x_i   = x[2*k +: 2];
            y_i   = y[2*k +: 2];
            is_i  = 1'($urandom);
        end
        tick();
        rdy_i = 1'b0;
        is_i  = inv;
        x_i   = 2'($urandom);
        y_i   = 2'($urandom);
        #1;
        if (glitch != 0) exp_err = 1'b1;
        if (exp_q.size() != 0 && !out_rdy_i) exp_ovf = 1'b1;
        else exp_q.push_back(ref_model(x, y, inv));
    endtask

    always @(negedge clk) begin
        if (!rst && out_vld_o) begin
            if (exp_q.size() == 0) begin
                chk("spurious_vld", out_vld_o, 0);
            end else begin
                chk("cos", cos_o, exp_q[0].c);
                chk("sin", sin_o, exp_q[0].s);
                chk("sat", sat_o, exp_q[0].sat);
                if (out_rdy_i) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [11:0] rx, ry;
        logic        rinv;
        logic        chain;

        rst = 1'b1; rdy_i = 1'b0; x_i = '0; y_i = '0; is_i = 1'b0; out_rdy_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", out_vld_o, 0);
        chk("rst_cos", cos_o, 0);
        chk("rst_sin", sin_o, 0);
        chk("rst_sat", sat_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_err", err_o, 0);
        rst = 1'b0;
        tick();

        // 1234 straight through, valid exactly at cycle 8 for one cycle
        rdy_mode = 0;
        frame(12'h4D2, 12'h4D2, 1'b0, 0);
        tick();
        chk("latency_vld", out_vld_o, 1);
        tick();
        chk("vld_one_cycle", out_vld_o, 0);

        frame(12'h4D2, 12'h4D2, 1'b1, 0);
        tick(); tick();

        frame(12'h800, 12'h123, 1'b1, 0);
        tick(); tick();

        // Overflow: two frames at minimum period with the consumer stalled
        rdy_mode = 2;
        frame(12'h111, 12'h222, 1'b0, 0);
        frame(12'h333, 12'h444, 1'b0, 0);
        tick();
        chk("ovf_set", ovf_o, 1);
        repeat (3) tick();
        chk("held_vld", out_vld_o, 1);
        rdy_mode = 0;
        tick(); tick();
        chk("ovf_sticky", ovf_o, 1);
        chk("drained", exp_q.size(), 0);

        // rdy_i re-pulse during collection
        frame(12'h5A5, 12'hA5A, 1'b0, 3);
        repeat (10) tick();
        chk("err_set", err_o, 1);
        chk("no_second", exp_q.size(), 0);

        // Reset at cycle 4 of a frame, then a clean frame
        rdy_i = 1'b1;
        tick();
        rdy_i = 1'b0; x_i = 2'd1; y_i = 2'd2;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", out_vld_o, 0);
        chk("mid_rst_cos", cos_o, 0);
        chk("mid_rst_sin", sin_o, 0);
        chk("mid_rst_sat", sat_o, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        chk("mid_rst_err", err_o, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_idle", out_vld_o, 0);
        frame(12'h7FF, 12'h801, 1'b1, 0);
        tick();
        chk("clean_vld", out_vld_o, 1);
        tick(); tick();

        // Randomized frames with random backpressure and random back-to-back starts
        for (int n = 0; n < 40; n++) begin
            rdy_mode = int'($urandom_range(0, 1));
            rx   = 12'($urandom);
            ry   = 12'($urandom);
            if ($urandom_range(0, 7) == 0) rx = 12'h800;
            if ($urandom_range(0, 7) == 0) ry = 12'h800;
            rinv  = 1'($urandom);
            chain = 1'($urandom);
            frame(rx, ry, rinv, 0);
            if (!chain) repeat ($urandom_range(1, 3)) tick();
        end
        rdy_mode = 0;
        repeat (20) tick();
        chk("final_drain", exp_q.size(), 0);
        chk("final_vld", out_vld_o, 0);
        chk("final_ovf", ovf_o, exp_ovf);
        chk("final_err", err_o, exp_err);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
